wb2axil: RTL and testbench

- Wishbone classic (non-pipelined) 32-bit slave to AXI4-lite 64-bit master bridge.
- Lets a Wishbone initiator, such as the SoC peripheral interconnect, reach an AXI-lite target on a 64-bit data bus.
- Exactly one transaction is in flight at a time.
- Each Wishbone access becomes one AXI-lite write (AW+W+B) or one read (AR+R). The 32-bit word is placed in, or extracted from, the 64-bit lane chosen by address bit 2.

---
 rtl/wb2axil_if.sv | 58 +++++
 rtl/wb2axil.sv | 182 ++++++++++++++++++
 tb/tb_wb2axil.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb2axil_if.sv
// Bus bundle for the Wishbone-classic to AXI4-lite bridge.
// Signal names keep the bridge's port naming: i_* are driven towards the
// bridge and o_* are driven by it.
//   slave  : the bridge's view (Wishbone slave side plus AXI-lite master side)
//   master : the environment's view (Wishbone initiator plus AXI-lite target)
interface wb2axil_if #(
   parameter int unsigned AW = 12
);
   // Wishbone side (word address [AW-1:2])
   logic [AW-3:0] i_wb_adr;
   logic [31:0]   i_wb_dat;
   logic [3:0]    i_wb_sel;
   logic          i_wb_we;
   logic          i_wb_cyc;
   logic          i_wb_stb;
   logic [31:0]   o_wb_rdt;
   logic          o_wb_ack;
   logic          o_wb_err;
   // AXI-lite write channels
   logic [AW-1:0] o_awaddr;
   logic          o_awvalid;
   logic          i_awready;
   logic [63:0]   o_wdata;
   logic [7:0]    o_wstrb;
   logic          o_wvalid;
   logic          i_wready;
   logic [1:0]    i_bresp;
   logic          i_bvalid;
   logic          o_bready;
   // AXI-lite read channels
   logic [AW-1:0] o_araddr;
   logic          o_arvalid;
   logic          i_arready;
   logic [63:0]   i_rdata;
   logic [1:0]    i_rresp;
   logic          i_rvalid;
   logic          o_rready;

   modport slave (
      input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
      output o_wb_rdt, o_wb_ack, o_wb_err,
      output o_awaddr, o_awvalid, input i_awready,
      output o_wdata, o_wstrb, o_wvalid, input i_wready,
      input  i_bresp, i_bvalid, output o_bready,
      output o_araddr, o_arvalid, input i_arready,
      input  i_rdata, i_rresp, i_rvalid, output o_rready
   );

   modport master (
      output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
      input  o_wb_rdt, o_wb_ack, o_wb_err,
      input  o_awaddr, o_awvalid, output i_awready,
      input  o_wdata, o_wstrb, o_wvalid, output i_wready,
      output i_bresp, i_bvalid, input o_bready,
      input  o_araddr, o_arvalid, output i_arready,
      output i_rdata, i_rresp, i_rvalid, input o_rready
   );
endinterface

// File: rtl/wb2axil.sv
// Wishbone classic 32-bit slave to AXI4-lite 64-bit master bridge.
// One transaction in flight; the 32-bit word maps onto the 64-bit lane
// selected by byte-address bit 2 (word-address bit 0).
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    wb2axil_if.slave: Wishbone slave inputs/outputs and the
//          AXI-lite AW/W/B/AR/R master channels; all outputs registered.
module wb2axil #(
   parameter int unsigned AW = 12
) (
   input  logic     i_clk,
   input  logic     i_rst,
   wb2axil_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WADDR = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RRESP = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]    state,   state_n;
   logic          hi,      hi_n;
   logic [31:0]   rdt,     rdt_n;
   logic          ack,     ack_n;
   logic          err,     err_n;
   logic [AW-1:0] awaddr,  awaddr_n;
   logic          awvalid, awvalid_n;
   logic [63:0]   wdata,   wdata_n;
   logic [7:0]    wstrb,   wstrb_n;
   logic          wvalid,  wvalid_n;
   logic          bready,  bready_n;
   logic [AW-1:0] araddr,  araddr_n;
   logic          arvalid, arvalid_n;
   logic          rready,  rready_n;

   logic aw_hs_c;
   logic w_hs_c;
   logic unused_c;

   assign aw_hs_c  = awvalid & bus.i_awready;
   assign w_hs_c   = wvalid & bus.i_wready;
   // Only the error bit of the response code matters (OKAY/EXOKAY vs SLVERR/DECERR).
   assign unused_c = ^{bus.i_bresp[0], bus.i_rresp[0]};

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_IDLE;
         hi      <= 1'b0;
         rdt     <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         awaddr  <= '0;
         awvalid <= 1'b0;
         wdata   <= '0;
         wstrb   <= '0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         araddr  <= '0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
      end else begin
         state   <= state_n;
         hi      <= hi_n;
         rdt     <= rdt_n;
         ack     <= ack_n;
         err     <= err_n;
         awaddr  <= awaddr_n;
         awvalid <= awvalid_n;
         wdata   <= wdata_n;
         wstrb   <= wstrb_n;
         wvalid  <= wvalid_n;
         bready  <= bready_n;
         araddr  <= araddr_n;
         arvalid <= arvalid_n;
         rready  <= rready_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n   = state;
      hi_n      = hi;
      rdt_n     = rdt;
      ack_n     = 1'b0;
      err_n     = 1'b0;
      awaddr_n  = awaddr;
      awvalid_n = awvalid;
      wdata_n   = wdata;
      wstrb_n   = wstrb;
      wvalid_n  = wvalid;
      bready_n  = bready;
      araddr_n  = araddr;
      arvalid_n = arvalid;
      rready_n  = rready;

      case (state)
         S_IDLE: begin
            if (bus.i_wb_cyc && bus.i_wb_stb) begin
               hi_n = bus.i_wb_adr[0];
               if (bus.i_wb_we) begin
                  awaddr_n  = {bus.i_wb_adr, 2'b00};
                  wdata_n   = {bus.i_wb_dat, bus.i_wb_dat};
                  wstrb_n   = bus.i_wb_adr[0] ? {bus.i_wb_sel, 4'h0}
                                              : {4'h0, bus.i_wb_sel};
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  state_n   = S_WADDR;
               end else begin
                  araddr_n  = {bus.i_wb_adr, 2'b00};
                  arvalid_n = 1'b1;
                  state_n   = S_RADDR;
               end
            end
         end

         // A channel whose valid is already low has handshaken earlier.
         S_WADDR: begin
            if (aw_hs_c) awvalid_n = 1'b0;
            if (w_hs_c)  wvalid_n  = 1'b0;
            if ((!awvalid || aw_hs_c) && (!wvalid || w_hs_c)) begin
               bready_n = 1'b1;
               state_n  = S_WRESP;
            end
         end

         // Response is always consumed; the Wishbone completion is dropped on abort.
         S_WRESP: begin
            if (bus.i_bvalid) begin
               bready_n = 1'b0;
               if (bus.i_wb_cyc) begin
                  err_n = bus.i_bresp[1];
                  ack_n = !bus.i_bresp[1];
               end
               state_n = S_DONE;
            end
         end

         S_RADDR: begin
            if (bus.i_arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = S_RRESP;
            end
         end

         S_RRESP: begin
            if (bus.i_rvalid) begin
               rready_n = 1'b0;
               rdt_n    = hi ? bus.i_rdata[63:32] : bus.i_rdata[31:0];
               if (bus.i_wb_cyc) begin
                  err_n = bus.i_rresp[1];
                  ack_n = !bus.i_rresp[1];
               end
               state_n = S_DONE;
            end
         end

         // ack/err are visible for this single cycle only.
         S_DONE: state_n = S_IDLE;

         default: state_n = S_IDLE;
      endcase
   end

   assign bus.o_wb_rdt  = rdt;
   assign bus.o_wb_ack  = ack;
   assign bus.o_wb_err  = err;
   assign bus.o_awaddr  = awaddr;
   assign bus.o_awvalid = awvalid;
   assign bus.o_wdata   = wdata;
   assign bus.o_wstrb   = wstrb;
   assign bus.o_wvalid  = wvalid;
   assign bus.o_bready  = bready;
   assign bus.o_araddr  = araddr;
   assign bus.o_arvalid = arvalid;
   assign bus.o_rready  = rready;

endmodule

// File: tb/tb_wb2axil.sv
// Self-checking bench for wb2axil: directed Wishbone requests, a behavioural
// AXI-lite target with per-channel ready delays, a handshake monitor and a
// scoreboard of expected Wishbone completions.
module tb_wb2axil;

   localparam int unsigned AW = 12;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   wb2axil_if #(.AW(AW)) bus ();

   wb2axil #(.AW(AW)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        err;
      logic [31:0] rdt;
      int          lat;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int exp_ack = 0;
   int exp_err = 0;
   logic [31:0] model_rdt = '0;

   // AXI target configuration
   int          aw_delay = 0;
   int          w_delay  = 0;
   int          ar_delay = 0;
   logic        b_hold   = 1'b0;
   logic [1:0]  bresp_cfg = 2'b00;
   logic [1:0]  rresp_cfg = 2'b00;
   logic [63:0] rdata_cfg = '0;

   // Handshake monitor state
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
   int n_ack = 0, n_err = 0, viol = 0, cyc_cnt = 0;
   int t_aw = 0, t_w = 0;
   logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
   logic [63:0]   cap_wdata = '0;
   logic [7:0]    cap_wstrb = '0;
   logic          p_rst = 1'b1;
   logic          p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
   logic          p_arv = 1'b0, p_arr = 1'b0;
   logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
   logic [63:0]   p_wdata = '0;
   logic [7:0]    p_wstrb = '0;

   // Count handshakes, capture AXI payloads, flag protocol violations
   always @(posedge i_clk) begin
      cyc_cnt <= cyc_cnt + 1;
      p_rst   <= i_rst;
      if (!i_rst) begin
         if (bus.o_awvalid && bus.i_awready) begin
            n_aw <= n_aw + 1; cap_awaddr <= bus.o_awaddr; t_aw <= cyc_cnt;
         end
         if (bus.o_wvalid && bus.i_wready) begin
            n_w <= n_w + 1; cap_wdata <= bus.o_wdata; cap_wstrb <= bus.o_wstrb; t_w <= cyc_cnt;
         end
         if (bus.o_arvalid && bus.i_arready) begin
            n_ar <= n_ar + 1; cap_araddr <= bus.o_araddr;
         end
         if (bus.o_bready && bus.i_bvalid) n_b <= n_b + 1;
         if (bus.o_rready && bus.i_rvalid) n_r <= n_r + 1;
         if (bus.o_wb_ack) n_ack <= n_ack + 1;
         if (bus.o_wb_err) n_err <= n_err + 1;
         if ((bus.o_wb_ack && bus.o_wb_err) ||
             (bus.o_bready && !(n_aw == n_w && n_aw > n_b)) ||
             (bus.o_rready && !(n_ar > n_r)))
            viol <= viol + 1;
         if (!p_rst &&
             ((p_awv && !p_awr && (!bus.o_awvalid || bus.o_awaddr != p_awaddr)) ||
              (p_wv && !p_wr && (!bus.o_wvalid || bus.o_wdata != p_wdata || bus.o_wstrb != p_wstrb)) ||
              (p_arv && !p_arr && (!bus.o_arvalid || bus.o_araddr != p_araddr))))
            viol <= viol + 1;
      end
      p_awv <= bus.o_awvalid; p_awr <= bus.i_awready; p_awaddr <= bus.o_awaddr;
      p_wv  <= bus.o_wvalid;  p_wr  <= bus.i_wready;  p_wdata <= bus.o_wdata; p_wstrb <= bus.o_wstrb;
      p_arv <= bus.o_arvalid; p_arr <= bus.i_arready; p_araddr <= bus.o_araddr;
   end

   // Behavioural AXI-lite target; updates its outputs 2 time units after each edge
   initial begin
      int aw_wait = 0, w_wait = 0, ar_wait = 0;
      bus.i_awready = 1'b0; bus.i_wready = 1'b0; bus.i_arready = 1'b0;
      bus.i_bvalid = 1'b0; bus.i_bresp = 2'b00;
      bus.i_rvalid = 1'b0; bus.i_rresp = 2'b00; bus.i_rdata = '0;
      forever begin
         @(posedge i_clk);
         #2;
         if (bus.o_awvalid) begin bus.i_awready = (aw_wait >= aw_delay); aw_wait++; end
         else begin bus.i_awready = 1'b0; aw_wait = 0; end
         if (bus.o_wvalid) begin bus.i_wready = (w_wait >= w_delay); w_wait++; end
         else begin bus.i_wready = 1'b0; w_wait = 0; end
         if (bus.o_arvalid) begin bus.i_arready = (ar_wait >= ar_delay); ar_wait++; end
         else begin bus.i_arready = 1'b0; ar_wait = 0; end
         bus.i_bvalid = !b_hold && (n_aw == n_w) && (n_aw > n_b);
         bus.i_bresp  = bresp_cfg;
         bus.i_rvalid = (n_ar > n_r);
         bus.i_rresp  = rresp_cfg;
         bus.i_rdata  = rdata_cfg;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_rdt"}, 64'(bus.o_wb_rdt), 64'd0);
      check({pfx, "_ctl"}, 64'({bus.o_wb_ack, bus.o_wb_err, bus.o_awvalid, bus.o_wvalid,
                               bus.o_bready, bus.o_arvalid, bus.o_rready}), 64'd0);
      check({pfx, "_addr"}, 64'({bus.o_awaddr, bus.o_araddr}), 64'd0);
      check({pfx, "_wdata"}, bus.o_wdata, 64'd0);
      check({pfx, "_wstrb"}, 64'(bus.o_wstrb), 64'd0);
   endtask

   // Drive a request and push its expected completion
   task automatic issue(input logic we, input logic [AW-3:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int lat);
      exp_t e;
      bus.i_wb_we = we; bus.i_wb_adr = adr; bus.i_wb_dat = dat; bus.i_wb_sel = sel;
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
      if (!we) model_rdt = adr[0] ? rdata_cfg[63:32] : rdata_cfg[31:0];
      e.err = we ? bresp_cfg[1] : rresp_cfg[1];
      e.rdt = model_rdt;
      e.lat = lat;
      if (e.err) exp_err++; else exp_ack++;
      sb.push_back(e);
   endtask

   // Wait (bounded) for ack/err and compare against the scoreboard head
   task automatic complete();
      exp_t e;
      int lat = 0;
      do begin step(1); lat++; end while (!(bus.o_wb_ack || bus.o_wb_err) && lat < 40);
      if (sb.size() == 0) begin
         check("sb_size", 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      check("latency", 64'(lat), 64'(e.lat));
      check("ack", 64'(bus.o_wb_ack), 64'(!e.err));
      check("err", 64'(bus.o_wb_err), 64'(e.err));
      check("rdt", 64'(bus.o_wb_rdt), 64'(e.rdt));
   endtask

   task automatic release_bus();
      bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
   endtask

   initial begin
      int n0, a0, e0, b0, wt;
      bus.i_wb_adr = '0; bus.i_wb_dat = '0; bus.i_wb_sel = '0;
      bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
      step(3);
      check_zero("reset");
      i_rst = 1'b0;
      step(1);

      // Zero-wait write to the high lane
      issue(1'b1, 10'h3, 32'hCAFEF00D, 4'hF, 3);
      complete();
      release_bus();
      check("wr_awaddr", 64'(cap_awaddr), 64'h00C);
      check("wr_wstrb", 64'(cap_wstrb), 64'hF0);
      check("wr_wdata", cap_wdata, 64'hCAFEF00D_CAFEF00D);
      step(2);

      // Skewed write: W accepted after 1 wait, AW after 4
      aw_delay = 4; w_delay = 1;
      issue(1'b1, 10'h1, 32'h12345678, 4'h3, 7);
      complete();
      release_bus();
      check("skew_w_first", 64'(t_w < t_aw), 64'd1);
      check("skew_wstrb", 64'(cap_wstrb), 64'h30);
      check("skew_awaddr", 64'(cap_awaddr), 64'h004);
      aw_delay = 0; w_delay = 0;
      step(2);

      // Reads from the low and high lanes
      rdata_cfg = 64'h11112222_33334444;
      issue(1'b0, 10'h2, 32'h0, 4'hF, 3);
      complete();
      release_bus();
      check("rd_lo_araddr", 64'(cap_araddr), 64'h008);
      step(1);
      issue(1'b0, 10'h3, 32'h0, 4'hF, 3);
      complete();
      release_bus();
      check("rd_hi_araddr", 64'(cap_araddr), 64'h00C);
      step(1);

      // Error responses: SLVERR read then DECERR write
      rdata_cfg = 64'hDEADBEEF_0BADF00D; rresp_cfg = 2'b10;
      issue(1'b0, 10'h0, 32'h0, 4'hF, 3);
      complete();
      release_bus();
      step(1);
      bresp_cfg = 2'b11;
      issue(1'b1, 10'h5, 32'hA5A5A5A5, 4'h1, 3);
      complete();
      release_bus();
      rresp_cfg = 2'b00; bresp_cfg = 2'b00;
      step(1);

      // Back-to-back reads with stb held high
      rdata_cfg = 64'h89ABCDEF_01234567;
      n0 = n_ar;
      issue(1'b0, 10'h0, 32'h0, 4'hF, 3);
      complete();
      issue(1'b0, 10'h1, 32'h0, 4'hF, 4);
      complete();
      release_bus();
      step(3);
      check("b2b_ar_count", 64'(n_ar - n0), 64'd2);

      // Master abort while waiting for the write response
      a0 = n_ack; e0 = n_err; b0 = n_b;
      b_hold = 1'b1;
      bus.i_wb_we = 1'b1; bus.i_wb_adr = 10'h7; bus.i_wb_dat = 32'h55AA55AA; bus.i_wb_sel = 4'hF;
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
      wt = 0;
      do begin step(1); wt++; end while (!bus.o_bready && wt < 20);
      check("abort_in_wresp", 64'(bus.o_bready), 64'd1);
      release_bus();
      b_hold = 1'b0;
      step(4);
      check("abort_b_consumed", 64'(n_b - b0), 64'd1);
      check("abort_no_ack", 64'(n_ack - a0), 64'd0);
      check("abort_no_err", 64'(n_err - e0), 64'd0);
      check("abort_bready_low", 64'(bus.o_bready), 64'd0);
      issue(1'b0, 10'h2, 32'h0, 4'hF, 3);
      complete();
      release_bus();
      step(1);

      // Reset while stalled in RADDR
      ar_delay = 1000;
      bus.i_wb_we = 1'b0; bus.i_wb_adr = 10'h4;
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
      step(3);
      check("raddr_stalled", 64'(bus.o_arvalid), 64'd1);
      release_bus();
      i_rst = 1'b1;
      step(1);
      check_zero("midrst");
      i_rst = 1'b0;
      ar_delay = 0;
      model_rdt = '0;
      step(1);
      rdata_cfg = 64'hFEEDFACE_C0FFEE00;
      issue(1'b0, 10'h9, 32'h0, 4'hF, 3);
      complete();
      release_bus();
      step(3);

      check("total_ack", 64'(n_ack), 64'(exp_ack));
      check("total_err", 64'(n_err), 64'(exp_err));
      check("protocol", 64'(viol), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of run, expected completion before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
